// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB constants: RoB tag width and broadcast source encoding,
// used by the RoB, RS, LSB and the CDB arbiter.
package cdb_arbiter_pkg;

    localparam int ROB_SIZE_WIDTH = 4;

    typedef enum logic {
        CDB_SRC_ALU = 1'b0,
        CDB_SRC_LSB = 1'b1
    } cdb_src_e;

endpackage

// File: rtl/cdb_skid_fifo.sv
// Per-source result FIFO: push/pop in one cycle, head visible combinationally.
// Flush empties it in one cycle; the caller guarantees no push when full.
module cdb_skid_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter int ROB_ID_W  = ROB_SIZE_WIDTH,
    parameter int BUF_DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic [ROB_ID_W-1:0]        i_rob_id,
    input  logic [31:0]                i_value,
    input  logic                       i_pop,
    output logic [ROB_ID_W-1:0]        o_head_rob_id,
    output logic [31:0]                o_head_value,
    output logic [$clog2(BUF_DEPTH):0] o_count
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

    logic [ROB_ID_W-1:0] r_id_mem  [BUF_DEPTH];
    logic [31:0]         r_val_mem [BUF_DEPTH];
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [CNT_W-1:0]    r_count;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (i_push && !i_flush) begin
            r_id_mem[r_wr_ptr]  <= i_rob_id;
            r_val_mem[r_wr_ptr] <= i_value;
        end
    end

    always_ff @(posedge clk) begin
        if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (i_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head_rob_id = r_id_mem[r_rd_ptr];
    assign o_head_value  = r_val_mem[r_rd_ptr];
    assign o_count       = r_count;

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: ALU/LSB results -> one registered broadcast per cycle, 1-cycle latency,
// round-robin (CDB_ARB_FIXED_PRIO_EN: LSB wins ties); ready drops while a FIFO is full.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int ROB_ID_W  = ROB_SIZE_WIDTH,
    parameter int BUF_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                rob_clear,
    input  logic                alu_valid,
    input  logic [ROB_ID_W-1:0] alu_rob_id,
    input  logic [31:0]         alu_value,
    output logic                alu_ready,
    input  logic                lsb_valid,
    input  logic [ROB_ID_W-1:0] lsb_rob_id,
    input  logic [31:0]         lsb_value,
    output logic                lsb_ready,
    output logic                cdb_valid,
    output logic [ROB_ID_W-1:0] cdb_rob_id,
    output logic [31:0]         cdb_value,
    output logic                cdb_src
);

    localparam int                CNT_W   = $clog2(BUF_DEPTH) + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(BUF_DEPTH);

    logic                w_flush;
    logic [CNT_W-1:0]    w_alu_count, w_lsb_count;
    logic [ROB_ID_W-1:0] w_alu_head_id, w_lsb_head_id;
    logic [31:0]         w_alu_head_val, w_lsb_head_val;
    logic                w_alu_xfer, w_lsb_xfer;
    logic                w_alu_nempty, w_lsb_nempty;
    logic                w_alu_has, w_lsb_has;
    logic                w_alu_push, w_lsb_push, w_alu_pop, w_lsb_pop;
    logic                w_grant;
    cdb_src_e            w_win, w_both_pick;
    logic [ROB_ID_W-1:0] w_win_id;
    logic [31:0]         w_win_val;

    assign w_flush   = rst || (rob_clear && rdy);
    assign alu_ready = rdy && (w_alu_count < DEPTH_C);
    assign lsb_ready = rdy && (w_lsb_count < DEPTH_C);

    assign w_alu_xfer   = alu_valid && alu_ready;
    assign w_lsb_xfer   = lsb_valid && lsb_ready;
    assign w_alu_nempty = (w_alu_count != '0);
    assign w_lsb_nempty = (w_lsb_count != '0);
    // An empty FIFO offers the incoming beat directly (bypass).
    assign w_alu_has    = rdy && !w_flush && (w_alu_nempty || w_alu_xfer);
    assign w_lsb_has    = rdy && !w_flush && (w_lsb_nempty || w_lsb_xfer);

`ifdef CDB_ARB_FIXED_PRIO_EN
    assign w_both_pick = CDB_SRC_LSB;
`else
    cdb_src_e r_last_grant;

    always_ff @(posedge clk) begin
        if (w_flush)      r_last_grant <= CDB_SRC_LSB;
        else if (w_grant) r_last_grant <= w_win;
    end

    assign w_both_pick = (r_last_grant == CDB_SRC_LSB) ? CDB_SRC_ALU : CDB_SRC_LSB;
`endif

    always_comb begin
        w_grant   = w_alu_has || w_lsb_has;
        w_win     = CDB_SRC_ALU;
        w_win_id  = '0;
        w_win_val = '0;
        if (w_alu_has && w_lsb_has) w_win = w_both_pick;
        else if (w_lsb_has)         w_win = CDB_SRC_LSB;
        if (w_win == CDB_SRC_LSB) begin
            w_win_id  = w_lsb_nempty ? w_lsb_head_id  : lsb_rob_id;
            w_win_val = w_lsb_nempty ? w_lsb_head_val : lsb_value;
        end else begin
            w_win_id  = w_alu_nempty ? w_alu_head_id  : alu_rob_id;
            w_win_val = w_alu_nempty ? w_alu_head_val : alu_value;
        end
    end

    // A bypassed winning beat never enters its FIFO; every other accepted beat does.
    assign w_alu_pop  = w_grant && (w_win == CDB_SRC_ALU) && w_alu_nempty;
    assign w_lsb_pop  = w_grant && (w_win == CDB_SRC_LSB) && w_lsb_nempty;
    assign w_alu_push = w_alu_xfer && !(w_grant && (w_win == CDB_SRC_ALU) && !w_alu_nempty);
    assign w_lsb_push = w_lsb_xfer && !(w_grant && (w_win == CDB_SRC_LSB) && !w_lsb_nempty);

    cdb_skid_fifo #(.ROB_ID_W(ROB_ID_W), .BUF_DEPTH(BUF_DEPTH)) u_alu_fifo (
        .clk           (clk),
        .i_flush       (w_flush),
        .i_push        (w_alu_push),
        .i_rob_id      (alu_rob_id),
        .i_value       (alu_value),
        .i_pop         (w_alu_pop),
        .o_head_rob_id (w_alu_head_id),
        .o_head_value  (w_alu_head_val),
        .o_count       (w_alu_count)
    );

    cdb_skid_fifo #(.ROB_ID_W(ROB_ID_W), .BUF_DEPTH(BUF_DEPTH)) u_lsb_fifo (
        .clk           (clk),
        .i_flush       (w_flush),
        .i_push        (w_lsb_push),
        .i_rob_id      (lsb_rob_id),
        .i_value       (lsb_value),
        .i_pop         (w_lsb_pop),
        .o_head_rob_id (w_lsb_head_id),
        .o_head_value  (w_lsb_head_val),
        .o_count       (w_lsb_count)
    );

    always_ff @(posedge clk) begin
        if (w_flush) begin
            cdb_valid  <= 1'b0;
            cdb_rob_id <= '0;
            cdb_value  <= '0;
            cdb_src    <= CDB_SRC_ALU;
        end else if (rdy) begin
            cdb_valid <= w_grant;
            if (w_grant) begin
                cdb_rob_id <= w_win_id;
                cdb_value  <= w_win_val;
                cdb_src    <= w_win;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed steps then random traffic, checked against a
// queue-based model of the two sources and the arbitration rule.
module tb_cdb_arbiter;

    localparam int ID_W  = 4;
    localparam int DEPTH = 2;
`ifdef CDB_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst, rdy, rob_clear;
    logic            alu_valid, lsb_valid, alu_ready, lsb_ready;
    logic [ID_W-1:0] alu_rob_id, lsb_rob_id, cdb_rob_id;
    logic [31:0]     alu_value, lsb_value, cdb_value;
    logic            cdb_valid, cdb_src;

    cdb_arbiter #(.ROB_ID_W(ID_W), .BUF_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .rob_clear  (rob_clear),
        .alu_valid  (alu_valid),
        .alu_rob_id (alu_rob_id),
        .alu_value  (alu_value),
        .alu_ready  (alu_ready),
        .lsb_valid  (lsb_valid),
        .lsb_rob_id (lsb_rob_id),
        .lsb_value  (lsb_value),
        .lsb_ready  (lsb_ready),
        .cdb_valid  (cdb_valid),
        .cdb_rob_id (cdb_rob_id),
        .cdb_value  (cdb_value),
        .cdb_src    (cdb_src)
    );

    always #5 clk = ~clk;

    typedef logic [ID_W+31:0] ent_t;
    ent_t            qa[$], ql[$];
    logic            m_vld, m_src, m_lg;
    logic [ID_W-1:0] m_id;
    logic [31:0]     m_val;
    bit              known = 1'b0;
    int              total = 0, bad = 0;
    int              n_acc = 0, n_seen = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check readies mid-cycle, advance the model, check cdb_* after the edge.
    task automatic tick();
        logic ear, elr, w;
        bit   ha, hl;
        ent_t e;
        @(negedge clk);
        ear = rdy && (qa.size() < DEPTH);
        elr = rdy && (ql.size() < DEPTH);
        if (known) begin
            chk("alu_ready", alu_ready, ear);
            chk("lsb_ready", lsb_ready, elr);
        end
        if (rst || (rob_clear && rdy)) begin
            qa.delete(); ql.delete();
            m_vld = 0; m_id = '0; m_val = '0; m_src = 0; m_lg = 1;
            if (rst) known = 1'b1;
        end else if (rdy && known) begin
            if (alu_valid && ear) begin qa.push_back({alu_rob_id, alu_value}); n_acc++; end
            if (lsb_valid && elr) begin ql.push_back({lsb_rob_id, lsb_value}); n_acc++; end
            ha = qa.size() > 0;
            hl = ql.size() > 0;
            if (ha && hl) w = FIXED ? 1'b1 : ~m_lg;
            else          w = hl;
            if (ha || hl) begin
                e = w ? ql.pop_front() : qa.pop_front();
                m_vld = 1; m_id = e[ID_W+31:32]; m_val = e[31:0]; m_src = w; m_lg = w;
            end else begin
                m_vld = 0;
            end
        end
        @(posedge clk);
        #1;
        if (known) begin
            if (cdb_valid === 1'b1) n_seen++;
            chk("cdb_valid", cdb_valid, m_vld);
            chk("cdb_rob_id", cdb_rob_id, m_id);
            chk("cdb_value", cdb_value, m_val);
            chk("cdb_src", cdb_src, m_src);
        end
    endtask

    task automatic idle_in();
        alu_valid = 0; lsb_valid = 0; rob_clear = 0;
    endtask

    initial begin
        rst = 1; rdy = 1; rob_clear = 0;
        alu_valid = 0; alu_rob_id = '0; alu_value = '0;
        lsb_valid = 0; lsb_rob_id = '0; lsb_value = '0;
        tick();
        rst = 0;
        chk("rst_cdb_valid", cdb_valid, 1'b0);
        chk("rst_cdb_value", cdb_value, 32'h0);
        chk("rst_alu_ready", alu_ready, 1'b1);
        chk("rst_lsb_ready", lsb_ready, 1'b1);

        // single ALU beat: visible for exactly one cycle
        alu_valid = 1; alu_rob_id = 4'd3; alu_value = 32'h1234;
        tick();
        idle_in();
        chk("single_vld", cdb_valid, 1'b1);
        chk("single_id", cdb_rob_id, 32'd3);
        chk("single_val", cdb_value, 32'h1234);
        chk("single_src", cdb_src, 1'b0);
        tick();
        chk("single_once", cdb_valid, 1'b0);

        // simultaneous beats straight after reset
        rst = 1; tick(); rst = 0;
        alu_valid = 1; alu_rob_id = 4'd1; alu_value = 32'hA1;
        lsb_valid = 1; lsb_rob_id = 4'd2; lsb_value = 32'hB2;
        tick();
        idle_in();
        chk("simul_first", cdb_src, FIXED ? 1'b1 : 1'b0);
        tick();
        chk("simul_second", cdb_src, FIXED ? 1'b0 : 1'b1);
        tick();

        // saturation, then drain and confirm nothing was lost
        n_acc = 0; n_seen = 0;
        for (int i = 0; i < 10; i++) begin
            alu_valid = 1; alu_rob_id = ID_W'(i);      alu_value = 32'h100 + i;
            lsb_valid = 1; lsb_rob_id = ID_W'(i + 8);  lsb_value = 32'h200 + i;
            tick();
        end
        idle_in();
        for (int i = 0; i < 5; i++) tick();
        chk("sat_no_loss", n_seen, n_acc);

        // flush with one entry per FIFO plus a new ALU beat
        rst = 1; tick(); rst = 0;
        for (int i = 0; i < 2; i++) begin
            alu_valid = 1; alu_rob_id = ID_W'(i + 1); alu_value = 32'h300 + i;
            lsb_valid = 1; lsb_rob_id = ID_W'(i + 5); lsb_value = 32'h400 + i;
            tick();
        end
        lsb_valid = 0; rob_clear = 1; alu_rob_id = 4'd9; alu_value = 32'h999;
        tick();
        idle_in();
        chk("flush_vld", cdb_valid, 1'b0);
        chk("flush_id", cdb_rob_id, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("flush_quiet", cdb_valid, 1'b0);
        end

        // rdy low with pending entries: everything freezes, then resumes in order
        for (int i = 0; i < 2; i++) begin
            alu_valid = 1; alu_rob_id = ID_W'(i + 2); alu_value = 32'h500 + i;
            lsb_valid = 1; lsb_rob_id = ID_W'(i + 6); lsb_value = 32'h600 + i;
            tick();
        end
        rdy = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("frozen_alu_ready", alu_ready, 1'b0);
        end
        rdy = 1; idle_in();
        for (int i = 0; i < 4; i++) tick();

        // random traffic
        for (int i = 0; i < 600; i++) begin
            rst        = ($urandom_range(0, 99) == 0);
            rob_clear  = ($urandom_range(0, 29) == 0);
            rdy        = ($urandom_range(0, 9) != 0);
            alu_valid  = ($urandom_range(0, 9) < 6);
            lsb_valid  = ($urandom_range(0, 9) < 6);
            alu_rob_id = ID_W'($urandom);
            lsb_rob_id = ID_W'($urandom);
            alu_value  = $urandom;
            lsb_value  = $urandom;
            tick();
        end
        rst = 0; rdy = 1; idle_in();
        for (int i = 0; i < 5; i++) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
